id_stage_pipe: RTL and testbench

- Parametrised successor to the combinational decode stage. Decodes the MIPS logic, shift, LUI and LW subset.
- Resolves operands using EX/MEM forwarding, or interlocks when forwarding is disabled. Detects load-use hazards and inserts bubbles.
- Registers all results into an ID/EX output stage with stall and flush control.
- Sits between the IF/ID register and the EX stage, and owns the hazard-driven IF stall.

---
 rtl/id_stage_pipe_pkg.sv | 159 +++++++++++++++
 rtl/id_stage_pipe_operand_sel.sv | 61 ++++++
 rtl/id_stage_pipe.sv | 175 +++++++++++++++++
 tb/tb_id_stage_pipe.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pipe_pkg.sv
// ----------------------------------------------------------------------------
// id_stage_pipe_pkg
//
// Shared definitions for the pipelined decode stage:
//   - reset / zero constants (RstEnable, ZeroWord, NOPRegAddr)
//   - MIPS opcode and SPECIAL funct codes for the decoded subset
//   - EXE_*_OP ALU operation codes (8 bits) and EXE_RES_* result selects (3 bits)
//   - operand source selector and the decoded-instruction struct
//   - id_decode(): pure combinational decode of one instruction word
// ----------------------------------------------------------------------------
package id_stage_pipe_pkg;

    localparam logic        RstEnable  = 1'b1;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr = 5'b00000;

    // Primary opcodes
    localparam logic [5:0] EXE_SPECIAL = 6'b000000;
    localparam logic [5:0] EXE_ANDI    = 6'b001100;
    localparam logic [5:0] EXE_ORI     = 6'b001101;
    localparam logic [5:0] EXE_XORI    = 6'b001110;
    localparam logic [5:0] EXE_LUI     = 6'b001111;
    localparam logic [5:0] EXE_LW      = 6'b100011;

    // SPECIAL funct codes
    localparam logic [5:0] EXE_AND = 6'b100100;
    localparam logic [5:0] EXE_OR  = 6'b100101;
    localparam logic [5:0] EXE_XOR = 6'b100110;
    localparam logic [5:0] EXE_NOR = 6'b100111;
    localparam logic [5:0] EXE_SLL = 6'b000000;
    localparam logic [5:0] EXE_SRL = 6'b000010;
    localparam logic [5:0] EXE_SRA = 6'b000011;

    // ALU operations
    localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP = 8'b0000_0011;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;

    // Result selects
    localparam logic [2:0] EXE_RES_NOP        = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
    localparam logic [2:0] EXE_RES_LOAD_STORE = 3'b111;

    // Where an operand comes from. SRC_REG is the only source that reads the
    // register file and therefore the only one that can forward or hazard.
    typedef enum logic [2:0] {
        SRC_ZERO   = 3'd0,
        SRC_REG    = 3'd1,
        SRC_IMM_ZX = 3'd2,   // zero-extended imm16
        SRC_IMM_SX = 3'd3,   // sign-extended imm16
        SRC_IMM_HI = 3'd4,   // {imm16, 16'h0}
        SRC_SA     = 3'd5    // zero-extended shift amount
    } src_sel_e;

    typedef struct packed {
        logic       wreg;
        logic       is_load;
        logic       inst_invalid;
        logic [7:0] aluop;
        logic [2:0] alusel;
        logic [4:0] wd;
        src_sel_e   src1;
        src_sel_e   src2;
    } id_dec_t;

    function automatic id_dec_t id_decode(input logic [31:0] inst);
        id_dec_t    d;
        logic [5:0] op;
        logic [5:0] funct;
        logic [4:0] rt;
        logic [4:0] rd;
        op    = inst[31:26];
        funct = inst[5:0];
        rt    = inst[20:16];
        rd    = inst[15:11];

        d.wreg         = 1'b0;
        d.is_load      = 1'b0;
        d.inst_invalid = 1'b0;
        d.aluop        = EXE_NOP_OP;
        d.alusel       = EXE_RES_NOP;
        d.wd           = NOPRegAddr;
        d.src1         = SRC_ZERO;
        d.src2         = SRC_ZERO;

        case (op)
            EXE_SPECIAL: begin
                case (funct)
                    EXE_AND, EXE_OR, EXE_XOR, EXE_NOR: begin
                        d.wreg   = 1'b1;
                        d.alusel = EXE_RES_LOGIC;
                        d.wd     = rd;
                        d.src1   = SRC_REG;
                        d.src2   = SRC_REG;
                        case (funct)
                            EXE_AND: d.aluop = EXE_AND_OP;
                            EXE_OR:  d.aluop = EXE_OR_OP;
                            EXE_XOR: d.aluop = EXE_XOR_OP;
                            default: d.aluop = EXE_NOR_OP;
                        endcase
                    end
                    EXE_SLL, EXE_SRL, EXE_SRA: begin
                        d.wreg   = 1'b1;
                        d.alusel = EXE_RES_SHIFT;
                        d.wd     = rd;
                        d.src1   = SRC_SA;
                        d.src2   = SRC_REG;
                        case (funct)
                            EXE_SLL: d.aluop = EXE_SLL_OP;
                            EXE_SRL: d.aluop = EXE_SRL_OP;
                            default: d.aluop = EXE_SRA_OP;
                        endcase
                    end
                    default: d.inst_invalid = 1'b1;
                endcase
            end
            EXE_ANDI, EXE_ORI, EXE_XORI: begin
                d.wreg   = 1'b1;
                d.alusel = EXE_RES_LOGIC;
                d.wd     = rt;
                d.src1   = SRC_REG;
                d.src2   = SRC_IMM_ZX;
                case (op)
                    EXE_ANDI: d.aluop = EXE_AND_OP;
                    EXE_ORI:  d.aluop = EXE_OR_OP;
                    default:  d.aluop = EXE_XOR_OP;
                endcase
            end
            EXE_LUI: begin
                // LUI is executed as (imm << 16) | 0
                d.wreg   = 1'b1;
                d.alusel = EXE_RES_LOGIC;
                d.aluop  = EXE_OR_OP;
                d.wd     = rt;
                d.src1   = SRC_IMM_HI;
                d.src2   = SRC_ZERO;
            end
            EXE_LW: begin
                d.wreg    = 1'b1;
                d.is_load = 1'b1;
                d.alusel  = EXE_RES_LOAD_STORE;
                d.aluop   = EXE_LW_OP;
                d.wd      = rt;
                d.src1    = SRC_REG;
                d.src2    = SRC_IMM_SX;
            end
            default: d.inst_invalid = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_stage_pipe_operand_sel.sv
// ----------------------------------------------------------------------------
// id_operand_sel
//
// Resolves one register source operand. Priority: address 0 -> 0, EX write
// match -> ex_wdata, MEM write match -> mem_wdata, else register-file data.
// With FWD_EN=0 the EX/MEM matches are reported as hazards instead and the
// register-file value is passed through (it is never consumed while the
// hazard is up). A load in EX that writes this source is always a hazard.
//
// Ports:
//   addr, re          source address and read enable
//   rf_data           register-file read data
//   ex_wreg/ex_is_load/ex_wd/ex_wdata    EX-stage write tuple
//   mem_wreg/mem_wd/mem_wdata            MEM-stage write tuple
//   data              resolved operand
//   hazard            this source cannot be satisfied this cycle
// ----------------------------------------------------------------------------
module id_operand_sel #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter bit FWD_EN     = 1'b1
) (
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic                  re,
    input  logic [DATA_W-1:0]     rf_data,
    input  logic                  ex_wreg,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic                  mem_wreg,
    input  logic [REG_ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     data,
    output logic                  hazard
);

    logic live;
    logic ex_hit;
    logic mem_hit;

    // $0 is hard-wired, so it never matches a producer.
    assign live    = re && (addr != '0);
    assign ex_hit  = live && ex_wreg  && (ex_wd  == addr);
    assign mem_hit = live && mem_wreg && (mem_wd == addr);

    always_comb begin
        data = '0;
        if (!live) begin
            data = '0;
        end else if (FWD_EN && ex_hit) begin
            data = ex_wdata;
        end else if (FWD_EN && mem_hit) begin
            data = mem_wdata;
        end else begin
            data = rf_data;
        end
    end

    assign hazard = (ex_hit && ex_is_load) || (!FWD_EN && (ex_hit || mem_hit));

endmodule

// File: rtl/id_stage_pipe.sv
// ----------------------------------------------------------------------------
// id_stage_pipe
//
// Pipelined MIPS decode stage (logic / shift / LUI / LW subset). Decodes the
// IF/ID instruction, resolves operands by EX/MEM forwarding (or interlock when
// FWD_EN=0), detects load-use hazards and registers everything into an ID/EX
// output stage.
//
// Handshake: IF presents an instruction with if_valid_i. id_ready_o=1 means
// the instruction is consumed at this clk edge and IF may advance; it is
// flush_i | (!stall_i & !hazard). A hazard loads a bubble into ID/EX; stall_i
// holds ID/EX; flush_i clears ID/EX and discards the ID instruction. Accepted
// instructions appear on the outputs one cycle later with ex_valid_o=1.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   if_valid_i, pc_i, inst_i     instruction from IF/ID
//   id_ready_o                   instruction consumed this cycle
//   reg{1,2}_read_o/_addr_o      register-file read port (combinational)
//   reg{1,2}_data_i              register-file read data
//   ex_wreg_i, ex_is_load_i, ex_wd_i, ex_wdata_i   EX-stage producer
//   mem_wreg_i, mem_wd_i, mem_wdata_i              MEM-stage producer
//   stall_i, flush_i             back-pressure and kill from downstream
//   ex_valid_o ... pc_o          registered ID/EX fields
// ----------------------------------------------------------------------------
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int DATA_W     = 32,   // must be >= 32 for LUI/imm widening
    parameter int REG_ADDR_W = 5,
    parameter bit FWD_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid_i,
    input  logic [31:0]           pc_i,
    input  logic [31:0]           inst_i,
    output logic                  id_ready_o,
    output logic                  reg1_read_o,
    output logic                  reg2_read_o,
    output logic [REG_ADDR_W-1:0] reg1_addr_o,
    output logic [REG_ADDR_W-1:0] reg2_addr_o,
    input  logic [DATA_W-1:0]     reg1_data_i,
    input  logic [DATA_W-1:0]     reg2_data_i,
    input  logic                  ex_wreg_i,
    input  logic                  ex_is_load_i,
    input  logic [REG_ADDR_W-1:0] ex_wd_i,
    input  logic [DATA_W-1:0]     ex_wdata_i,
    input  logic                  mem_wreg_i,
    input  logic [REG_ADDR_W-1:0] mem_wd_i,
    input  logic [DATA_W-1:0]     mem_wdata_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic                  ex_valid_o,
    output logic                  wreg_o,
    output logic                  is_load_o,
    output logic                  inst_invalid_o,
    output logic [7:0]            aluop_o,
    output logic [2:0]            alusel_o,
    output logic [DATA_W-1:0]     reg1_o,
    output logic [DATA_W-1:0]     reg2_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic [31:0]           pc_o
);

    id_dec_t             dec;
    logic [DATA_W-1:0]   sel1_data;
    logic [DATA_W-1:0]   sel2_data;
    logic                haz1;
    logic                haz2;
    logic                hazard;
    logic [DATA_W-1:0]   op1;
    logic [DATA_W-1:0]   op2;

    assign dec = id_decode(inst_i);

    assign reg1_read_o = (dec.src1 == SRC_REG);
    assign reg2_read_o = (dec.src2 == SRC_REG);
    assign reg1_addr_o = REG_ADDR_W'(inst_i[25:21]);
    assign reg2_addr_o = REG_ADDR_W'(inst_i[20:16]);

    id_operand_sel #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_EN     (FWD_EN)
    ) u_sel1 (
        .addr       (reg1_addr_o),
        .re         (reg1_read_o),
        .rf_data    (reg1_data_i),
        .ex_wreg    (ex_wreg_i),
        .ex_is_load (ex_is_load_i),
        .ex_wd      (ex_wd_i),
        .ex_wdata   (ex_wdata_i),
        .mem_wreg   (mem_wreg_i),
        .mem_wd     (mem_wd_i),
        .mem_wdata  (mem_wdata_i),
        .data       (sel1_data),
        .hazard     (haz1)
    );

    id_operand_sel #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_EN     (FWD_EN)
    ) u_sel2 (
        .addr       (reg2_addr_o),
        .re         (reg2_read_o),
        .rf_data    (reg2_data_i),
        .ex_wreg    (ex_wreg_i),
        .ex_is_load (ex_is_load_i),
        .ex_wd      (ex_wd_i),
        .ex_wdata   (ex_wdata_i),
        .mem_wreg   (mem_wreg_i),
        .mem_wd     (mem_wd_i),
        .mem_wdata  (mem_wdata_i),
        .data       (sel2_data),
        .hazard     (haz2)
    );

    // An empty IF/ID slot has nothing to wait for.
    assign hazard     = if_valid_i && (haz1 || haz2);
    assign id_ready_o = flush_i || (!stall_i && !hazard);

    function automatic logic [DATA_W-1:0] pick_operand(
        input src_sel_e          src,
        input logic [DATA_W-1:0] reg_val,
        input logic [31:0]       inst
    );
        logic [DATA_W-1:0] v;
        v = '0;
        case (src)
            SRC_REG:    v = reg_val;
            SRC_IMM_ZX: v = DATA_W'(inst[15:0]);
            SRC_IMM_SX: v = DATA_W'($signed(inst[15:0]));
            SRC_IMM_HI: v = DATA_W'({inst[15:0], 16'h0000});
            SRC_SA:     v = DATA_W'(inst[10:6]);
            default:    v = '0;
        endcase
        return v;
    endfunction

    assign op1 = pick_operand(dec.src1, sel1_data, inst_i);
    assign op2 = pick_operand(dec.src2, sel2_data, inst_i);

    // ID/EX register. Reset, flush and a hazard bubble all load the same
    // cleared NOP image; stall holds.
    always_ff @(posedge clk) begin
        if (rst == RstEnable || flush_i || (!stall_i && hazard)) begin
            ex_valid_o     <= 1'b0;
            wreg_o         <= 1'b0;
            is_load_o      <= 1'b0;
            inst_invalid_o <= 1'b0;
            aluop_o        <= EXE_NOP_OP;
            alusel_o       <= EXE_RES_NOP;
            reg1_o         <= '0;
            reg2_o         <= '0;
            wd_o           <= REG_ADDR_W'(NOPRegAddr);
            pc_o           <= ZeroWord;
        end else if (!stall_i) begin
            // Side-effect flags are gated by if_valid_i so an empty slot
            // can never write a register or raise an exception.
            ex_valid_o     <= if_valid_i;
            wreg_o         <= if_valid_i && dec.wreg;
            is_load_o      <= if_valid_i && dec.is_load;
            inst_invalid_o <= if_valid_i && dec.inst_invalid;
            aluop_o        <= dec.aluop;
            alusel_o       <= dec.alusel;
            reg1_o         <= op1;
            reg2_o         <= op2;
            wd_o           <= REG_ADDR_W'(dec.wd);
            pc_o           <= pc_i;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// ----------------------------------------------------------------------------
// tb_id_stage_pipe
//
// Directed vectors against two instances: u_fwd (FWD_EN=1) and u_stl
// (FWD_EN=0), driven by the same IF/EX/MEM/control inputs. Each instance gets
// its register-file read data from a fixed model: reg[a] = a replicated into
// every byte (reg[2] = 0x02020202).
// ----------------------------------------------------------------------------
module tb_id_stage_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        if_valid_i;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
    logic [4:0]  ex_wd_i, mem_wd_i;
    logic [31:0] ex_wdata_i, mem_wdata_i;
    logic        stall_i, flush_i;

    // FWD_EN=1 instance outputs
    logic        f_ready, f_r1re, f_r2re;
    logic [4:0]  f_r1a, f_r2a;
    logic [31:0] f_r1d, f_r2d;
    logic        f_valid, f_wreg, f_load, f_inv;
    logic [7:0]  f_aluop;
    logic [2:0]  f_alusel;
    logic [31:0] f_reg1, f_reg2, f_pc;
    logic [4:0]  f_wd;

    // FWD_EN=0 instance outputs
    logic        s_ready, s_r1re, s_r2re;
    logic [4:0]  s_r1a, s_r2a;
    logic [31:0] s_r1d, s_r2d;
    logic        s_valid, s_wreg, s_load, s_inv;
    logic [7:0]  s_aluop;
    logic [2:0]  s_alusel;
    logic [31:0] s_reg1, s_reg2, s_pc;
    logic [4:0]  s_wd;

    function automatic logic [31:0] rf(input logic [4:0] a);
        return {4{3'b000, a}};
    endfunction

    assign f_r1d = rf(f_r1a);
    assign f_r2d = rf(f_r2a);
    assign s_r1d = rf(s_r1a);
    assign s_r2d = rf(s_r2a);

    id_stage_pipe #(.DATA_W(32), .REG_ADDR_W(5), .FWD_EN(1'b1)) u_fwd (
        .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .pc_i(pc_i), .inst_i(inst_i),
        .id_ready_o(f_ready), .reg1_read_o(f_r1re), .reg2_read_o(f_r2re),
        .reg1_addr_o(f_r1a), .reg2_addr_o(f_r2a), .reg1_data_i(f_r1d), .reg2_data_i(f_r2d),
        .ex_wreg_i(ex_wreg_i), .ex_is_load_i(ex_is_load_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .ex_valid_o(f_valid), .wreg_o(f_wreg), .is_load_o(f_load), .inst_invalid_o(f_inv),
        .aluop_o(f_aluop), .alusel_o(f_alusel), .reg1_o(f_reg1), .reg2_o(f_reg2),
        .wd_o(f_wd), .pc_o(f_pc)
    );

    id_stage_pipe #(.DATA_W(32), .REG_ADDR_W(5), .FWD_EN(1'b0)) u_stl (
        .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .pc_i(pc_i), .inst_i(inst_i),
        .id_ready_o(s_ready), .reg1_read_o(s_r1re), .reg2_read_o(s_r2re),
        .reg1_addr_o(s_r1a), .reg2_addr_o(s_r2a), .reg1_data_i(s_r1d), .reg2_data_i(s_r2d),
        .ex_wreg_i(ex_wreg_i), .ex_is_load_i(ex_is_load_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .ex_valid_o(s_valid), .wreg_o(s_wreg), .is_load_o(s_load), .inst_invalid_o(s_inv),
        .aluop_o(s_aluop), .alusel_o(s_alusel), .reg1_o(s_reg1), .reg2_o(s_reg2),
        .wd_o(s_wd), .pc_o(s_pc)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Queue the expected (reg1, reg2, wd) of the next issued instruction.
    task automatic expect_ops(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] wd);
        exp_q.push_back(r1);
        exp_q.push_back(r2);
        exp_q.push_back(wd);
    endtask

    task automatic check_ops(input string tag);
        logic [31:0] e1, e2, ew;
        if (exp_q.size() < 3) begin
            chk({tag, "_queue"}, 32'(exp_q.size()), 32'd3);
        end else begin
            e1 = exp_q.pop_front();
            e2 = exp_q.pop_front();
            ew = exp_q.pop_front();
            chk({tag, "_reg1"}, f_reg1, e1);
            chk({tag, "_reg2"}, f_reg2, e2);
            chk({tag, "_wd"}, 32'(f_wd), ew);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_inst(input logic [31:0] inst, input logic [31:0] pc);
        if_valid_i = 1'b1;
        inst_i     = inst;
        pc_i       = pc;
    endtask

    task automatic clear_bypass();
        ex_wreg_i    = 1'b0;
        ex_is_load_i = 1'b0;
        ex_wd_i      = 5'd0;
        ex_wdata_i   = 32'h0;
        mem_wreg_i   = 1'b0;
        mem_wd_i     = 5'd0;
        mem_wdata_i  = 32'h0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; if_valid_i = 1'b0; pc_i = 32'h0; inst_i = 32'h0;
        stall_i = 1'b0; flush_i = 1'b0;
        clear_bypass();
        tick(); tick();

        chk("rst_valid",  32'(f_valid),  32'd0);
        chk("rst_wreg",   32'(f_wreg),   32'd0);
        chk("rst_aluop",  32'(f_aluop),  32'h00);
        chk("rst_alusel", 32'(f_alusel), 32'd0);
        chk("rst_reg1",   f_reg1,        32'h0);
        chk("rst_pc",     f_pc,          32'h0);
        rst = 1'b0;

        // ORI $1,$0,0x1100
        drive_inst(32'h3401_1100, 32'h0000_0100);
        expect_ops(32'h0, 32'h0000_1100, 32'd1);
        #1 chk("ori_ready", 32'(f_ready), 32'd1);
        tick();
        chk("ori_valid", 32'(f_valid), 32'd1);
        chk("ori_wreg",  32'(f_wreg),  32'd1);
        chk("ori_aluop", 32'(f_aluop), 32'h25);
        chk("ori_pc",    f_pc,         32'h0000_0100);
        check_ops("ori");

        // OR $3,$1,$2 with EX and MEM both writing $1: EX wins
        drive_inst(32'h0022_1825, 32'h0000_0104);
        ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_wdata_i = 32'hAAAA_0000;
        mem_wreg_i = 1'b1; mem_wd_i = 5'd1; mem_wdata_i = 32'h0000_5555;
        expect_ops(32'hAAAA_0000, 32'h0202_0202, 32'd3);
        #1 chk("or_fwd_ready", 32'(f_ready), 32'd1);
        chk("or_nofwd_ready", 32'(s_ready), 32'd0);
        tick();
        check_ops("or_fwd");
        chk("or_alusel", 32'(f_alusel), 32'd1);
        clear_bypass();

        // LUI $7,0xBEEF
        drive_inst(32'h3C07_BEEF, 32'h0000_0108);
        expect_ops(32'hBEEF_0000, 32'h0, 32'd7);
        tick();
        check_ops("lui");
        chk("lui_aluop", 32'(f_aluop), 32'h25);

        // LW $8,-4($9)
        drive_inst(32'h8D28_FFFC, 32'h0000_010C);
        expect_ops(32'h0909_0909, 32'hFFFF_FFFC, 32'd8);
        tick();
        check_ops("lw");
        chk("lw_isload", 32'(f_load),   32'd1);
        chk("lw_aluop",  32'(f_aluop),  32'hE3);
        chk("lw_alusel", 32'(f_alusel), 32'd7);

        // SRA $10,$11,5
        drive_inst(32'h000B_5143, 32'h0000_0110);
        expect_ops(32'h0000_0005, 32'h0B0B_0B0B, 32'd10);
        tick();
        check_ops("sra");
        chk("sra_aluop",  32'(f_aluop),  32'h03);
        chk("sra_alusel", 32'(f_alusel), 32'd2);

        // Load-use: LW $4 in EX, AND $5,$4,$4 in ID
        drive_inst(32'h0084_2824, 32'h0000_0114);
        ex_wreg_i = 1'b1; ex_is_load_i = 1'b1; ex_wd_i = 5'd4; ex_wdata_i = 32'h1234_5678;
        #1 chk("lu_ready", 32'(f_ready), 32'd0);
        tick();
        chk("lu_bubble_valid", 32'(f_valid), 32'd0);
        chk("lu_bubble_wreg",  32'(f_wreg),  32'd0);
        ex_is_load_i = 1'b0;
        expect_ops(32'h1234_5678, 32'h1234_5678, 32'd5);
        #1 chk("lu_ready_after", 32'(f_ready), 32'd1);
        tick();
        chk("lu_issue_valid", 32'(f_valid), 32'd1);
        chk("lu_issue_aluop", 32'(f_aluop), 32'h24);
        check_ops("lu_issue");
        clear_bypass();

        // stall for 3 cycles with ORI $6,$0,0xFF waiting in ID
        drive_inst(32'h3406_00FF, 32'h0000_0118);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_ready", 32'(f_ready), 32'd0);
            tick();
            chk("stall_hold_wd",    32'(f_wd),    32'd5);
            chk("stall_hold_aluop", 32'(f_aluop), 32'h24);
            chk("stall_hold_valid", 32'(f_valid), 32'd1);
        end
        stall_i = 1'b0;
        expect_ops(32'h0, 32'h0000_00FF, 32'd6);
        #1 chk("stall_release_ready", 32'(f_ready), 32'd1);
        tick();
        check_ops("stall_release");
        chk("stall_release_pc", f_pc, 32'h0000_0118);

        // flush together with stall: flush wins
        drive_inst(32'h3401_1100, 32'h0000_011C);
        stall_i = 1'b1; flush_i = 1'b1;
        #1 chk("flush_ready", 32'(f_ready), 32'd1);
        tick();
        chk("flush_valid", 32'(f_valid), 32'd0);
        chk("flush_wreg",  32'(f_wreg),  32'd0);
        chk("flush_aluop", 32'(f_aluop), 32'h00);
        stall_i = 1'b0; flush_i = 1'b0;

        // invalid opcode 0x3F
        drive_inst(32'hFC00_0000, 32'h0000_0120);
        tick();
        chk("inv_valid", 32'(f_valid), 32'd1);
        chk("inv_flag",  32'(f_inv),   32'd1);
        chk("inv_wreg",  32'(f_wreg),  32'd0);
        chk("inv_aluop", 32'(f_aluop), 32'h00);

        // FWD_EN=0: MEM writing $2 interlocks OR $3,$1,$2 until it clears
        drive_inst(32'h0022_1825, 32'h0000_0124);
        mem_wreg_i = 1'b1; mem_wd_i = 5'd2; mem_wdata_i = 32'h0000_DEAD;
        #1 chk("nofwd_ready", 32'(s_ready), 32'd0);
        chk("fwd_mem_ready", 32'(f_ready), 32'd1);
        tick();
        chk("nofwd_bubble1", 32'(s_valid), 32'd0);
        chk("fwd_mem_reg2",  f_reg2,       32'h0000_DEAD);
        tick();
        chk("nofwd_bubble2", 32'(s_valid), 32'd0);
        mem_wreg_i = 1'b0;
        #1 chk("nofwd_ready_after", 32'(s_ready), 32'd1);
        tick();
        chk("nofwd_valid", 32'(s_valid), 32'd1);
        chk("nofwd_reg1",  s_reg1,       32'h0101_0101);
        chk("nofwd_reg2",  s_reg2,       32'h0202_0202);
        chk("nofwd_wd",    32'(s_wd),    32'd3);
        clear_bypass();

        // reset mid-stall
        drive_inst(32'h3401_1100, 32'h0000_0128);
        stall_i = 1'b1; rst = 1'b1;
        tick();
        chk("rst2_valid", 32'(f_valid), 32'd0);
        chk("rst2_aluop", 32'(f_aluop), 32'h00);
        chk("rst2_reg1",  f_reg1,       32'h0);
        chk("rst2_wd",    32'(f_wd),    32'd0);
        chk("rst2_pc",    f_pc,         32'h0);
        chk("rst2_s_valid", 32'(s_valid), 32'd0);
        rst = 1'b0; stall_i = 1'b0;
        expect_ops(32'h0, 32'h0000_1100, 32'd1);
        #1 chk("rst2_ready", 32'(f_ready), 32'd1);
        tick();
        chk("rst2_resume_valid", 32'(f_valid), 32'd1);
        check_ops("rst2_resume");

        // empty IF slot loads an invalid-free bubble
        if_valid_i = 1'b0;
        tick();
        chk("idle_valid", 32'(f_valid), 32'd0);
        chk("idle_wreg",  32'(f_wreg),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
